// File: rtl/sem_pkg.sv
// sem_pkg: shared state encoding and constants for the semaphore configuration sequencer
package sem_pkg;
  typedef enum logic [3:0] {
    IDLE,
    STOP,
    WAIT_DATA,
    WRITE_RAM,
    SET_DIV,
    CHECK,
    START,
    DONE,
    ERR
  } state_t;
  localparam logic CTL_ADDR_RUN = 1'b0;
  localparam logic CTL_ADDR_DIV = 1'b1;
  localparam int N_PERIODS = 4;
  localparam int MODE_W = 2;
endpackage

// File: rtl/sem_seq_timer.sv
// sem_seq_timer: clearable up-counter flagging when TIMEOUT-1 idle cycles have elapsed
module sem_seq_timer #(
  parameter int TIMEOUT = 1024,
  localparam int W = $clog2(TIMEOUT)
) (
  input  logic clk,
  input  logic clrn,
  input  logic clr_i,
  output logic expire_o
);
  logic [W-1:0] cnt_q;
  // count every cycle the owner keeps the timer running, restart from zero on clear
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) cnt_q <= '0;
    else cnt_q <= clr_i ? '0 : cnt_q + 1'b1;
  end
  assign expire_o = cnt_q == W'(TIMEOUT - 1);
endmodule

// File: rtl/sem_seq.sv
// sem_seq: stops the semaphore, loads four period words, programs and verifies the divider, restarts
module sem_seq
  import sem_pkg::*;
#(
  parameter int M = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              load,
  input  logic [MODE_W-1:0] mode,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic [M-1:0]      per_data,
  input  logic              per_valid,
  output logic              per_ready,
  output logic              ctl_wr,
  output logic              ctl_rd,
  output logic              ctl_addr,
  output logic [31:0]       ctl_wrdata,
  input  logic [31:0]       ctl_rddata,
  output logic              ram_wr,
  output logic [3:0]        ram_addr,
  output logic [31:0]       ram_wrdata
);
  localparam int IDX_W = $clog2(N_PERIODS);
  state_t state_q, state_d;
  logic [MODE_W-1:0] mode_q;
  logic [IDX_W-1:0] idx_q;
  logic start, accept, expire;
  logic busy_d, done_d, err_d, per_ready_d, ctl_wr_d, ctl_rd_d, ctl_addr_d, ram_wr_d;
  logic [31:0] ctl_wrdata_d, ram_wrdata_d;
  logic [3:0] ram_addr_d;
  logic unused_rddata;
  assign unused_rddata = ^ctl_rddata[31:MODE_W];
  assign start = state_q == IDLE && load;
  assign accept = state_q == WAIT_DATA && per_valid && per_ready;
  sem_seq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .clrn     (clrn),
    .clr_i    (state_q != WAIT_DATA),
    .expire_o (expire)
  );
  // state, datapath and registered outputs; outputs are decoded from the next state so they line up with it
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= IDLE;
      mode_q     <= '0;
      idx_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      per_ready  <= 1'b0;
      ctl_wr     <= 1'b0;
      ctl_rd     <= 1'b0;
      ctl_addr   <= 1'b0;
      ctl_wrdata <= '0;
      ram_wr     <= 1'b0;
      ram_addr   <= '0;
      ram_wrdata <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= start ? mode : mode_q;
      idx_q      <= start ? '0 : state_q == WRITE_RAM ? idx_q + 1'b1 : idx_q;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
      per_ready  <= per_ready_d;
      ctl_wr     <= ctl_wr_d;
      ctl_rd     <= ctl_rd_d;
      ctl_addr   <= ctl_addr_d;
      ctl_wrdata <= ctl_wrdata_d;
      ram_wr     <= ram_wr_d;
      ram_addr   <= ram_addr_d;
      ram_wrdata <= ram_wrdata_d;
    end
  end
  // sequencing; a failed divider readback skips START so the run bit stays cleared
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = load ? STOP : IDLE;
      STOP:      state_d = WAIT_DATA;
      WAIT_DATA: state_d = accept ? WRITE_RAM : expire ? ERR : WAIT_DATA;
      WRITE_RAM: state_d = idx_q == IDX_W'(N_PERIODS - 1) ? SET_DIV : WAIT_DATA;
      SET_DIV:   state_d = CHECK;
      CHECK:     state_d = ctl_rddata[MODE_W-1:0] == mode_q ? START : ERR;
      START:     state_d = DONE;
      DONE:      state_d = IDLE;
      ERR:       state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end
  // next-cycle output values; every bus returns to zero outside its access cycle
  always_comb begin
    busy_d       = state_d != IDLE;
    done_d       = state_d == DONE;
    err_d        = state_d == ERR || (err && !start);
    per_ready_d  = state_d == WAIT_DATA;
    ctl_wr_d     = state_d inside {STOP, SET_DIV, START};
    ctl_rd_d     = state_d == CHECK;
    ctl_addr_d   = state_d inside {SET_DIV, CHECK} ? CTL_ADDR_DIV : CTL_ADDR_RUN;
    ctl_wrdata_d = state_d == SET_DIV ? 32'(mode_q) : state_d == START ? 32'd1 : 32'd0;
    ram_wr_d     = state_d == WRITE_RAM;
    ram_addr_d   = ram_wr_d ? {mode_q, idx_q} : 4'd0;
    ram_wrdata_d = ram_wr_d ? 32'(per_data) : 32'd0;
  end
endmodule

// File: tb/tb_sem_seq.sv
// tb_sem_seq: scoreboard bench for sem_seq with a small semaphore model and a stalling period stream
module tb_sem_seq;
  localparam int M = 8;
  localparam int TO = 16;
  typedef struct {
    int          kind;
    int          addr;
    logic [31:0] data;
  } ev_t;
  typedef struct {
    int         stall;
    logic [7:0] d;
  } src_t;
  logic clk = 1'b0;
  logic clrn = 1'b0;
  logic load = 1'b0;
  logic [1:0] mode = 2'd0;
  logic busy, done, err, per_ready, ctl_wr, ctl_rd, ctl_addr, ram_wr;
  logic [M-1:0] per_data = '0;
  logic per_valid = 1'b0;
  logic [31:0] ctl_wrdata, ctl_rddata, ram_wrdata;
  logic [3:0] ram_addr;
  logic [1:0] div_reg = 2'd0;
  logic run_reg = 1'b0;
  logic bad = 1'b0;
  logic flush = 1'b0;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int run1_cnt = 0;
  ev_t exp_q[$];
  src_t src[$];
  sem_seq #(.M(M), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .load       (load),
    .mode       (mode),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .per_data   (per_data),
    .per_valid  (per_valid),
    .per_ready  (per_ready),
    .ctl_wr     (ctl_wr),
    .ctl_rd     (ctl_rd),
    .ctl_addr   (ctl_addr),
    .ctl_wrdata (ctl_wrdata),
    .ctl_rddata (ctl_rddata),
    .ram_wr     (ram_wr),
    .ram_addr   (ram_addr),
    .ram_wrdata (ram_wrdata)
  );
  always #5 clk = ~clk;
  // semaphore control registers; 'bad' corrupts the divider readback
  always @(posedge clk) begin
    if (ctl_wr && ctl_addr) div_reg <= ctl_wrdata[1:0];
    if (ctl_wr && !ctl_addr) run_reg <= ctl_wrdata[0];
  end
  assign ctl_rddata = ctl_addr ? (bad ? 32'd0 : {30'd0, div_reg}) : {31'd0, run_reg};
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, want);
    end
  endtask
  function automatic void push_ev(input int kind, input int addr, input logic [31:0] data);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endfunction
  function automatic void feed(input logic [7:0] a, b, c, d, input int stall_b);
    src_t s;
    s.stall = 0; s.d = a; src.push_back(s);
    s.stall = stall_b; s.d = b; src.push_back(s);
    s.stall = 0; s.d = c; src.push_back(s);
    s.d = d; src.push_back(s);
  endfunction
  // kinds: 0 ctl write, 1 ram write, 2 done pulse, 3 ctl read
  function automatic void push_seq(input int m, input logic [7:0] a, b, c, d, input bit good);
    push_ev(0, 0, 0);
    push_ev(1, m * 4 + 0, {24'd0, a});
    push_ev(1, m * 4 + 1, {24'd0, b});
    push_ev(1, m * 4 + 2, {24'd0, c});
    push_ev(1, m * 4 + 3, {24'd0, d});
    push_ev(0, 1, m);
    push_ev(3, 1, 0);
    if (good) begin
      push_ev(0, 0, 1);
      push_ev(2, 0, 0);
    end
  endfunction
  task automatic sb(input int kind, input int addr, input logic [31:0] data);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got kind %0d addr %0d data %0h expected no access", kind, addr, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.addr != addr || e.data !== data) begin
        errors++;
        $display("FAIL sb_access: got kind %0d addr %0d data %0h expected kind %0d addr %0d data %0h",
                 kind, addr, data, e.kind, e.addr, e.data);
      end
    end
  endtask
  // monitor: every strobe or done pulse is matched against the next expected access
  initial forever begin
    @(negedge clk);
    if (clrn) begin
      if (ctl_wr) sb(0, int'(ctl_addr), ctl_wrdata);
      if (ctl_rd) sb(3, int'(ctl_addr), 32'd0);
      if (ram_wr) sb(1, int'(ram_addr), ram_wrdata);
      if (done) sb(2, 0, 0);
      if (done) done_cnt++;
      if (ctl_wr && !ctl_addr && ctl_wrdata == 32'd1) run1_cnt++;
    end
  end
  // period stream: stall counts only cycles where the sequencer is ready
  initial begin
    bit acc;
    acc = 1'b0;
    forever begin
      @(negedge clk);
      if (flush) begin
        src.delete();
        per_valid = 1'b0;
        acc = 1'b0;
      end
      if (acc) begin
        per_valid = 1'b0;
        acc = 1'b0;
      end
      if (!per_valid && src.size() > 0) begin
        if (src[0].stall > 0) begin
          if (per_ready) src[0].stall = src[0].stall - 1;
        end else begin
          per_data = src[0].d;
          src.pop_front();
          per_valid = 1'b1;
        end
      end
      acc = per_valid && per_ready;
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  // one operation; cycle 1 is the cycle after load is sampled
  task automatic op(input logic [1:0] m, input int pulse_at, output int dcyc, output int ecyc, output int erise);
    int cyc;
    dcyc = 0;
    erise = 0;
    @(negedge clk);
    load = 1'b1;
    mode = m;
    @(negedge clk);
    load = 1'b0;
    cyc = 1;
    chk("busy_c1", busy, 1);
    chk("err_clear_c1", err, 0);
    while (busy && cyc < 200) begin
      @(negedge clk);
      cyc++;
      load = cyc == pulse_at;
      if (done) dcyc = cyc;
      if (err && erise == 0) erise = cyc;
    end
    load = 1'b0;
    ecyc = cyc;
    if (busy) chk("op_timeout", busy, 0);
  endtask
  initial begin
    int d, e, r, d0, r0;
    #7;
    chk("reset_outputs", 32'(|{busy, done, err, per_ready, ctl_wr, ctl_rd, ctl_addr, ram_wr, ram_addr,
                               ctl_wrdata, ram_wrdata}), 0);
    #5 clrn = 1'b1;
    feed(5, 6, 7, 8, 0);
    push_seq(2, 5, 6, 7, 8, 1);
    op(2, 0, d, e, r);
    chk("t1_done_cycle", d, 13);
    chk("t1_idle_cycle", e, 14);
    chk("t1_err", err, 0);
    chk("t1_run", run_reg, 1);
    chk("t1_q_empty", exp_q.size(), 0);
    feed(8'h11, 8'h22, 8'h33, 8'h44, 3);
    push_seq(2, 8'h11, 8'h22, 8'h33, 8'h44, 1);
    op(2, 0, d, e, r);
    chk("t2_done_cycle", d, 16);
    chk("t2_idle_cycle", e, 17);
    chk("t2_q_empty", exp_q.size(), 0);
    push_ev(0, 0, 0);
    op(1, 0, d, e, r);
    chk("t3_err_rise", r == 18 || r == 19, 1);
    chk("t3_idle_cycle", e, 19);
    chk("t3_no_done", d, 0);
    chk("t3_err", err, 1);
    chk("t3_run_off", run_reg, 0);
    chk("t3_q_empty", exp_q.size(), 0);
    bad = 1'b1;
    feed(1, 2, 3, 4, 0);
    push_seq(3, 1, 2, 3, 4, 0);
    op(3, 0, d, e, r);
    chk("t4_err_rise", r == 12 || r == 13, 1);
    chk("t4_idle_cycle", e, 13);
    chk("t4_no_done", d, 0);
    chk("t4_err", err, 1);
    chk("t4_run_off", run_reg, 0);
    chk("t4_q_empty", exp_q.size(), 0);
    bad = 1'b0;
    d0 = done_cnt;
    r0 = run1_cnt;
    feed(0, 255, 128, 1, 0);
    push_seq(1, 0, 255, 128, 1, 1);
    op(1, 5, d, e, r);
    repeat (5) @(negedge clk);
    chk("t5_done_cycle", d, 13);
    chk("t5_busy", busy, 0);
    chk("t5_one_done", done_cnt - d0, 1);
    chk("t5_one_run", run1_cnt - r0, 1);
    chk("t5_err", err, 0);
    chk("t5_q_empty", exp_q.size(), 0);
    feed(9, 10, 11, 12, 0);
    push_ev(0, 0, 0);
    push_ev(1, 4, 9);
    @(negedge clk);
    load = 1'b1;
    mode = 2'd1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 20 && !ram_wr; i++) @(negedge clk);
    chk("t6_in_write", ram_wr, 1);
    #2 clrn = 1'b0;
    #1;
    chk("t6_async_zero", 32'(|{busy, done, err, per_ready, ctl_wr, ctl_rd, ctl_addr, ram_wr, ram_addr,
                               ctl_wrdata, ram_wrdata}), 0);
    flush = 1'b1;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("t6_q_empty_reset", exp_q.size(), 0);
    #2 clrn = 1'b1;
    feed(1, 2, 3, 4, 0);
    push_seq(0, 1, 2, 3, 4, 1);
    op(0, 0, d, e, r);
    chk("t6_done_cycle", d, 13);
    chk("t6_run", run_reg, 1);
    chk("t6_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sem_seq.md
# sem_seq

Configuration sequencer for the semaphore block. On a load command it stops the semaphore and streams four period words into the semaphore's period RAM bank for the selected divider mode. It then programs the divider, reads it back for verification and restarts the semaphore. It sits between the host-side period stream and the semaphore's control and memory slave ports, and is the only master on those ports.

## Interface
Parameters:
- M, 8, period width; equals the semaphore's divisor width
- TIMEOUT, 1024, max cycles in WAIT_DATA without an accepted word before abort (≥2)

Ports:
- clk  in  1  clock
- clrn  in  1  reset, asynchronous, active-low
- load  in  1  start request, sampled only in IDLE
- mode  in  2  divider mode/RAM bank to program, captured with load
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on successful completion
- err  out  1  sticky failure flag, cleared when the next load is accepted
- per_data  in  M  period word
- per_valid  in  1  per_data valid
- per_ready  out  1  sequencer can accept per_data
- ctl_wr  out  1  semaphore control write strobe
- ctl_rd  out  1  semaphore control read strobe
- ctl_addr  out  1  0 = run register, 1 = divider register
- ctl_wrdata  out  32  control write data
- ctl_rddata  in  32  control read data, combinational from ctl_addr
- ram_wr  out  1  period RAM write strobe
- ram_addr  out  4  {mode, index}
- ram_wrdata  out  32  period word, zero-extended from M bits

## Operation
- All outputs are registered. Reset values are all 0, including err, done and per_ready. State resets to IDLE.
- Strobes and addresses are asserted for exactly one cycle per access. Outside an access, ctl_* and ram_* drive 0.
- IDLE: when load=1, capture mode into mode_q, clear err and idx, then go to STOP. While busy, load is ignored.
- STOP: ctl_wr=1, ctl_addr=0, ctl_wrdata=0. Go to WAIT_DATA.
- WAIT_DATA: per_ready=1.
  - On per_valid & per_ready, register per_data and go to WRITE_RAM.
  - The timeout counter clears on entry and counts each cycle without acceptance. When it reaches TIMEOUT-1 with no acceptance, go to ERR.
- WRITE_RAM: ram_wr=1, ram_addr={mode_q, idx[1:0]}, ram_wrdata={(32-M)'0, word}.
  - If idx==3, go to SET_DIV. Otherwise increment idx and return to WAIT_DATA.
- SET_DIV: ctl_wr=1, ctl_addr=1, ctl_wrdata={30'0, mode_q}. Go to CHECK.
- CHECK: ctl_rd=1, ctl_addr=1. Sample ctl_rddata[1:0] at the end of the cycle.
  - If the sample equals mode_q, go to START. Otherwise go to ERR.
- START: ctl_wr=1, ctl_addr=0, ctl_wrdata=1. Go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- ERR: err=1, which holds until the next accepted load. Go to IDLE. The run bit stays 0 because no START write occurs.
- per_valid outside WAIT_DATA is not accepted, since per_ready=0. The stream holds the word until accepted.
- A period value of 0 is legal and is written unchanged.

## Timing
- Minimum latency, with per_valid held high: load sampled at edge 0; STOP in cycle 1; WAIT/WRITE pairs in cycles 2–9; SET_DIV in 10; CHECK in 11; START in 12; done high in cycle 13; busy low from cycle 14.
- Each per_valid stall adds cycles one-for-one inside WAIT_DATA.
- Timeout: ERR is entered exactly TIMEOUT cycles after entering WAIT_DATA if no word is accepted. err is high in the following cycle.
- Reset mid-operation: outputs drop to 0 immediately (asynchronously). The partial RAM bank contents are not restored.
- load and a per_valid arriving in the same cycle as IDLE: load is taken. The word waits for WAIT_DATA.

## Structure
- Package sem_pkg:
  - state enum: IDLE, STOP, WAIT_DATA, WRITE_RAM, SET_DIV, CHECK, START, DONE, ERR
  - constants CTL_ADDR_RUN=0, CTL_ADDR_DIV=1, N_PERIODS=4, MODE_W=2
- One sub-module, sem_seq_timer: a clearable up-counter of width $clog2(TIMEOUT) with an expire flag, instantiated once for the WAIT_DATA timeout.

## Test plan
- load, mode=2, per_data stream 5,6,7,8 with valid always high, model rddata=mode → RAM writes at addresses 8,9,10,11 with data 5..8; ctl writes (0,0), (1,2), (0,1); done in cycle 13; err=0.
- Same load with per_valid low for 3 cycles before the second word → done in cycle 16, and the data order is preserved.
- load, mode=1, no per_valid for TIMEOUT=16 cycles → err=1 one cycle after expiry; no ram_wr; the last ctl write is run=0; busy=0.
- Model returns rddata[1:0]=0 on readback with mode=3 → err=1 after CHECK; no run=1 write; done stays 0.
- load pulsed again while busy → ignored; exactly one run=1 write and one done pulse occur.
- clrn asserted in WRITE_RAM → all outputs 0 immediately; a subsequent load, mode=0 completes normally with addresses 0..3.
